// File: rtl/naneye_stream_gen.sv
// NanEye-style serial stream source: frame sync, raw line sync and Manchester pixel
// words with programmable per-half-bit jitter, plus reference pixel/sync strobes.
module naneye_stream_gen #(
    parameter int                 D_WIDTH    = 10,
    parameter int                 COLS       = 250,
    parameter int                 ROWS       = 250,
    parameter int                 HALF_DIV   = 3,
    parameter int                 JITTER_MAX = 1,
    parameter int                 FSYNC_BITS = 24,
    parameter logic [D_WIDTH+1:0] LSYNC_WORD = 12'hFC0,
    parameter logic [D_WIDTH-1:0] PIX_CONST  = 10'h2AA
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               ENABLE,
    input  logic [1:0]         PATTERN_MODE,
    input  logic [1:0]         JITTER_MODE,
    output logic               SER_OUT,
    output logic [D_WIDTH-1:0] PIX_DATA,
    output logic               PIX_VALID,
    output logic               LINE_START,
    output logic               FRAME_START,
    output logic               BUSY
);
    localparam int WW    = D_WIDTH + 2;
    localparam int HFS   = 2 * FSYNC_BITS;
    localparam int HWD   = 2 * WW;
    localparam int HMAX0 = (HFS > HWD) ? HFS : HWD;
    localparam int HMAX  = (HMAX0 > 16) ? HMAX0 : 16;
    localparam int HIW   = $clog2(HMAX + 1);
    localparam int CW    = $clog2(HALF_DIV + JITTER_MAX + 1);
    localparam int COLW  = $clog2(COLS + 1);
    localparam int ROWW  = $clog2(ROWS + 1);

    localparam logic [HIW-1:0]  FS_LAST  = HIW'(HFS - 1);
    localparam logic [HIW-1:0]  WD_LAST  = HIW'(HWD - 1);
    localparam logic [HIW-1:0]  GAP_LAST = HIW'(15);
    localparam logic [COLW-1:0] COL_LAST = COLW'(COLS - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(ROWS - 1);

    // Fibonacci tap masks for maximal-length LFSRs, widths 2..16
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:       return 32'h0003;
            3:       return 32'h0006;
            4:       return 32'h000C;
            5:       return 32'h0014;
            6:       return 32'h0030;
            7:       return 32'h0060;
            8:       return 32'h00B8;
            9:       return 32'h0110;
            11:      return 32'h0500;
            12:      return 32'h0829;
            13:      return 32'h100D;
            14:      return 32'h2015;
            15:      return 32'h6000;
            16:      return 32'hD008;
            default: return 32'h0240;
        endcase
    endfunction

    localparam logic [31:0]        TAPS_ALL = lfsr_taps(D_WIDTH);
    localparam logic [D_WIDTH-1:0] PIX_TAPS = TAPS_ALL[D_WIDTH-1:0];

    typedef enum logic [2:0] {IDLE, FSYNC, LSYNC, PIXEL, FGAP} state_t;

    state_t              state, n_state;
    logic [CW-1:0]       cnt, len_m1;
    logic [HIW-1:0]      hidx, n_hidx;
    logic [WW-1:0]       word, n_word, sh;
    logic [COLW-1:0]     col, n_col;
    logic [ROWW-1:0]     row, n_row;
    logic [D_WIDTH-1:0]  ramp, pix_lfsr, pix_val, pix_next;
    logic [7:0]          jit_lfsr, jit_next;
    logic                step, hb, ld_pix, ld_lsync, n_ser, n_fs, n_ls, n_pv;
    int                  jmag, jit, hlen;

    // Length of the half-bit that starts at this boundary
    always_comb begin
        jmag = int'(jit_lfsr) % (JITTER_MAX + 1);
        jit  = 0;
        if (JITTER_MAX > 0) begin
            case (JITTER_MODE)
                2'd1:    jit = jit_lfsr[7] ? -jmag : jmag;
                2'd2:    jit = jmag;
                2'd3:    jit = -jmag;
                default: jit = 0;
            endcase
        end
        hlen = HALF_DIV + jit;
        if (hlen < 1) hlen = 1;
        len_m1   = CW'(hlen - 1);
        jit_next = {jit_lfsr[6:0], jit_lfsr[7] ^ jit_lfsr[5] ^ jit_lfsr[4] ^ jit_lfsr[3]};
        pix_next = {pix_lfsr[D_WIDTH-2:0], ^(pix_lfsr & PIX_TAPS)};
        case (PATTERN_MODE)
            2'd1:    pix_val = PIX_CONST;
            2'd2:    pix_val = pix_lfsr;
            default: pix_val = ramp;
        endcase
    end

    always_comb begin
        n_state   = state;
        n_hidx    = hidx + 1'b1;
        n_col     = col;
        n_row     = row;
        n_fs      = 1'b0;
        n_ls      = 1'b0;
        n_pv      = 1'b0;
        ld_pix    = 1'b0;
        ld_lsync  = 1'b0;
        hb        = 1'b0;
        step      = (state == IDLE) ? ENABLE : (cnt == '0);
        case (state)
            IDLE: if (ENABLE) begin
                n_state = FSYNC; n_hidx = '0; n_row = '0; n_fs = 1'b1; hb = 1'b1;
            end
            FSYNC: if (step) begin
                hb = 1'b1;
                if (hidx == FS_LAST) begin
                    n_state = LSYNC; n_hidx = '0; n_ls = 1'b1; ld_lsync = 1'b1;
                end
            end
            LSYNC: if (step) begin
                hb = 1'b1;
                if (hidx == WD_LAST) begin
                    n_state = PIXEL; n_hidx = '0; n_col = '0; n_pv = 1'b1; ld_pix = 1'b1;
                end
            end
            PIXEL: if (step) begin
                hb = 1'b1;
                if (hidx == WD_LAST) begin
                    n_hidx = '0;
                    if (col == COL_LAST) begin
                        if (row == ROW_LAST) n_state = FGAP;
                        else begin
                            n_row = row + 1'b1; n_state = LSYNC; n_ls = 1'b1; ld_lsync = 1'b1;
                        end
                    end else begin
                        n_col = col + 1'b1; n_pv = 1'b1; ld_pix = 1'b1;
                    end
                end
            end
            FGAP: if (step) begin
                if (hidx != GAP_LAST) hb = 1'b1;
                else if (ENABLE) begin
                    n_state = FSYNC; n_hidx = '0; n_row = '0; n_fs = 1'b1; hb = 1'b1;
                end else begin
                    n_state = IDLE; n_hidx = '0;
                end
            end
            default: n_state = IDLE;
        endcase
        n_word = ld_lsync ? LSYNC_WORD : (ld_pix ? {1'b1, pix_val, 1'b0} : word);
        // Bit being sent is word MSB after shifting out hidx/2 bits
        sh = n_word << n_hidx[HIW-1:1];
        case (n_state)
            FSYNC:   n_ser = 1'b1;
            LSYNC:   n_ser = sh[WW-1];
            PIXEL:   n_ser = sh[WW-1] ^ n_hidx[0];
            default: n_ser = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            cnt         <= '0;
            hidx        <= '0;
            word        <= '0;
            col         <= '0;
            row         <= '0;
            ramp        <= '0;
            pix_lfsr    <= D_WIDTH'(1);
            jit_lfsr    <= 8'hA5;
            SER_OUT     <= 1'b0;
            PIX_DATA    <= '0;
            PIX_VALID   <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            PIX_VALID   <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            if (step) begin
                state       <= n_state;
                hidx        <= n_hidx;
                col         <= n_col;
                row         <= n_row;
                word        <= n_word;
                SER_OUT     <= n_ser;
                BUSY        <= (n_state != IDLE);
                FRAME_START <= n_fs;
                LINE_START  <= n_ls;
                PIX_VALID   <= n_pv;
                if (hb) begin
                    cnt      <= len_m1;
                    jit_lfsr <= jit_next;
                end
                if (ld_pix) begin
                    PIX_DATA <= pix_val;
                    ramp     <= ramp + 1'b1;
                    pix_lfsr <= pix_next;
                end
            end else if (state != IDLE) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_naneye_stream_gen.sv
// Bench for naneye_stream_gen: expected waveform is built half-bit by half-bit from
// the frame layout, then compared cycle by cycle against the DUT.
module tb_naneye_stream_gen;
    localparam int DW = 10, NC = 4, NR = 2, HD = 3, JM = 1, FSB = 24;

    logic       CLOCK = 1'b0, RESET_N = 1'b1, ENABLE = 1'b0;
    logic [1:0] PATTERN_MODE = 2'd0, JITTER_MODE = 2'd0;
    logic       SER_OUT, PIX_VALID, LINE_START, FRAME_START, BUSY;
    logic [DW-1:0] PIX_DATA;

    always #5 CLOCK = ~CLOCK;

    naneye_stream_gen #(.D_WIDTH(DW), .COLS(NC), .ROWS(NR), .HALF_DIV(HD),
                        .JITTER_MAX(JM), .FSYNC_BITS(FSB)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE),
        .PATTERN_MODE(PATTERN_MODE), .JITTER_MODE(JITTER_MODE),
        .SER_OUT(SER_OUT), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .LINE_START(LINE_START), .FRAME_START(FRAME_START), .BUSY(BUSY));

    typedef struct packed {logic ser, pv, ls, fs, busy; logic [DW-1:0] pix;} cyc_t;
    typedef struct {int pat, jm, frames, pv, ls, pvf, gap, pix0;} vec_t;

    cyc_t exp_q[$];
    vec_t tbl[6];
    int checks = 0, failures = 0;
    logic [DW-1:0] m_ramp, m_plfsr, m_pix;
    logic [7:0]    m_jlfsr;
    int drop_idx, obs_pv, obs_fs, first_ls, first_pv, fs_gap, last_fs, pix0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ramp = '0; m_plfsr = 10'd1; m_jlfsr = 8'hA5; m_pix = '0;
    endtask

    // Half-bit length HALF_DIV + j; jitter LFSR is x^8+x^6+x^5+x^4+1
    function automatic int half_len(input int jm);
        int m, j;
        m = int'(m_jlfsr) % (JM + 1);
        case (jm)
            1:       j = m_jlfsr[7] ? -m : m;
            2:       j = m;
            3:       j = -m;
            default: j = 0;
        endcase
        m_jlfsr = {m_jlfsr[6:0], m_jlfsr[7] ^ m_jlfsr[5] ^ m_jlfsr[4] ^ m_jlfsr[3]};
        return (HD + j < 1) ? 1 : HD + j;
    endfunction

    task automatic push_half(input logic lvl, input logic pv, input logic ls,
                             input logic fs, input int jm);
        int n;
        cyc_t c;
        n = half_len(jm);
        for (int k = 0; k < n; k++) begin
            c.ser = lvl; c.pv = pv && (k == 0); c.ls = ls && (k == 0);
            c.fs = fs && (k == 0); c.busy = 1'b1; c.pix = m_pix;
            exp_q.push_back(c);
        end
    endtask

    task automatic push_frame(input int pat, input int jm, input bit last);
        logic [11:0] lsw, w;
        logic [DW-1:0] v;
        lsw = 12'hFC0;
        for (int h = 0; h < 2 * FSB; h++) push_half(1'b1, 1'b0, 1'b0, h == 0, jm);
        for (int r = 0; r < NR; r++) begin
            for (int h = 0; h < 24; h++) push_half(lsw[11 - h / 2], 1'b0, h == 0, 1'b0, jm);
            for (int c = 0; c < NC; c++) begin
                if (last && r == 0 && c == 2) drop_idx = exp_q.size();
                case (pat)
                    1:       v = 10'h2AA;
                    2:       v = m_plfsr;
                    default: v = m_ramp;
                endcase
                m_ramp  = m_ramp + 1'b1;
                m_plfsr = {m_plfsr[8:0], m_plfsr[9] ^ m_plfsr[6]};  // x^10+x^7+1
                m_pix   = v;
                w = {1'b1, v, 1'b0};
                for (int h = 0; h < 24; h++)
                    push_half(w[11 - h / 2] ^ (h % 2 == 1), h == 0, 1'b0, 1'b0, jm);
            end
        end
        for (int h = 0; h < 16; h++) push_half(1'b0, 1'b0, 1'b0, 1'b0, jm);
    endtask

    task automatic run(input int pat, input int jm, input int frames, input int abort_at);
        cyc_t got, c;
        exp_q.delete();
        drop_idx = -1;
        for (int f = 0; f < frames; f++) push_frame(pat, jm, f == frames - 1);
        c = '{ser: 1'b0, pv: 1'b0, ls: 1'b0, fs: 1'b0, busy: 1'b0, pix: m_pix};
        repeat (4) exp_q.push_back(c);
        obs_pv = 0; obs_fs = 0; first_ls = -1; first_pv = -1; fs_gap = -1; last_fs = -1; pix0 = -1;
        @(negedge CLOCK);
        PATTERN_MODE = 2'(pat); JITTER_MODE = 2'(jm); ENABLE = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) break;
            @(negedge CLOCK);
            got = {SER_OUT, PIX_VALID, LINE_START, FRAME_START, BUSY, PIX_DATA};
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                if (failures <= 10)
                    $display("FAIL cyc pat=%0d jm=%0d i=%0d got=%h exp=%h", pat, jm, i, got, exp_q[i]);
            end
            if (PIX_VALID) begin
                if (obs_pv == 0) begin first_pv = i; pix0 = int'(PIX_DATA); end
                obs_pv++;
            end
            if (LINE_START && first_ls < 0) first_ls = i;
            if (FRAME_START) begin
                if (last_fs >= 0 && fs_gap < 0) fs_gap = i - last_fs;
                last_fs = i;
                obs_fs++;
            end
            if (i == drop_idx) ENABLE = 1'b0;
        end
    endtask

    initial begin
        // pat, jm, frames, #pix_valid, first LINE_START, first PIX_VALID, FRAME_START gap, first pixel
        tbl[0] = '{0, 0, 1, 8,  144, 216, -1,  0};
        tbl[1] = '{1, 0, 1, 8,  144, 216, -1,  10'h2AA};
        tbl[2] = '{0, 2, 1, 8,  -1,  -1,  -1,  -1};
        tbl[3] = '{2, 3, 2, 16, -1,  -1,  -1,  -1};
        tbl[4] = '{3, 1, 1, 8,  -1,  -1,  -1,  -1};
        tbl[5] = '{0, 0, 2, 16, 144, 216, 912, -1};

        model_reset();
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_ser", int'(SER_OUT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_strobes", int'({PIX_VALID, LINE_START, FRAME_START}), 0);
        chk("rst_pix", int'(PIX_DATA), 0);
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("idle_busy", int'(BUSY), 0);
        chk("idle_ser", int'(SER_OUT), 0);

        for (int r = 0; r < 6; r++) begin
            run(tbl[r].pat, tbl[r].jm, tbl[r].frames, -1);
            chk("pv_count", obs_pv, tbl[r].pv);
            chk("fs_count", obs_fs, tbl[r].frames);
            if (tbl[r].ls >= 0)   chk("first_ls", first_ls, tbl[r].ls);
            if (tbl[r].pvf >= 0)  chk("first_pv", first_pv, tbl[r].pvf);
            if (tbl[r].gap >= 0)  chk("fs_gap", fs_gap, tbl[r].gap);
            if (tbl[r].pix0 >= 0) chk("first_pix", pix0, tbl[r].pix0);
        end

        for (int n = 0; n < 4; n++) begin
            int p, j, f;
            p = int'($urandom_range(0, 3));
            j = int'($urandom_range(0, 3));
            f = int'($urandom_range(1, 2));
            run(p, j, f, -1);
            chk("rnd_pv_count", obs_pv, 8 * f);
        end

        // Reset in the middle of the first line's pixels, then a fresh frame
        run(0, 0, 1, 300);
        #3 RESET_N = 1'b0;
        ENABLE = 1'b0;
        #1;
        chk("async_ser", int'(SER_OUT), 0);
        chk("async_busy", int'(BUSY), 0);
        chk("async_strobes", int'({PIX_VALID, LINE_START, FRAME_START}), 0);
        model_reset();
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        run(0, 0, 1, -1);
        chk("post_rst_pix0", pix0, 0);
        chk("post_rst_pv", obs_pv, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
